npc_select_unit: RTL and testbench
==================================

// Module: npc_select_unit
// PURPOSE
//   Owns the PC register and the status flags (Z, N). Generates the next-PC select lines
//   s1/s2/s3 consumed by the next-PC 4:1 mux, and loads the resulting PC each cycle.
//   Sequences the memory-indirect jump (jmxor) as a multi-cycle req/ack read and stalls the core meanwhile.
//   Drives the link write for taken balrv/baln.
// PARAMETERS
//   ADDR_W    32            PC / address width
//   RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
//   clk          in   1       core clock, rising edge
//   rst_n        in   1       async active-low reset
//   balrv        in   1       branch-and-link to register if Z
//   baln         in   1       branch-and-link to jump target if N
//   jmxor        in   1       memory-indirect jump: PC <= MEM[read_data1]
//   jsp          in   1       unconditional jump to register
//   flag_we      in   1       load Z/N from ALU this cycle
//   alu_zero     in   1       ALU zero result
//   alu_neg      in   1       ALU sign bit
//   read_data1   in   ADDR_W  register operand (target for s1 and jmxor pointer)
//   jump_target  in   ADDR_W  decoded jump target (s2)
//   mem_rdata    in   ADDR_W  data returned for the indirect read
//   mem_ack      in   1       read data valid, 1-cycle pulse
//   pc           out  ADDR_W  current PC
//   s1, s2, s3   out  1       next-PC mux selects
//   mem_req      out  1       indirect read request, held until mem_ack
//   mem_addr     out  ADDR_W  indirect read address
//   stall        out  1       freeze fetch/decode; no instruction retires
//   link_we      out  1       write link register
//   link_data    out  ADDR_W  pc+4 of the branching instruction
//   align_err    out  1       sticky misaligned-target flag (macro only; else tied 0)
// BEHAVIOUR
//   Reset: pc=RESET_PC, status=2'b00, FSM=RUN, mem_req=0, stall=0, link_we=0, align_err=0.
//   status[0]=Z, status[1]=N; on flag_we, status loads {alu_neg,alu_zero} at the clock edge.
//   Branches read the status value registered before this edge (flag written by a prior instruction).
//   s3=jmxor; s2=baln&status[1]; s1=(balrv&status[0])|jsp. All combinational. Forced 0 while FSM!=RUN.
//   Next PC priority: s3 > s2 > s1 > pc+4. pc+4 wraps modulo 2^ADDR_W.
//   RUN: if s2|s1, pc <= jump_target or read_data1; else pc <= pc+4.
//   RUN: if s3, latch mem_addr=read_data1, assert mem_req and stall, go to IND_WAIT; pc holds.
//   IND_WAIT: mem_req=1, stall=1; pc holds; status holds (flag_we ignored).
//   IND_WAIT + mem_ack: pc <= mem_rdata, mem_req drops same edge, go to RUN.
//   link_we=1 (1 cycle, RUN only) when a taken s2, or a taken s1 caused by balrv&Z.
//     jsp alone never links. link_data=pc+4.
//   Simultaneous s3 and s2/s1: s3 wins; no link write.
//   mem_ack in RUN is ignored.
//   rst_n low mid-IND_WAIT: aborts immediately; mem_req deasserts asynchronously.
// CONFIGURATION
//   NPC_ALIGN_CHK_EN defined: a branch target or mem_rdata with [1:0]!=0 is not loaded.
//     Instead pc <= pc+4 and align_err sets (sticky until reset).
//   NPC_ALIGN_CHK_EN undefined: targets are loaded unchanged; align_err is tied 0.
// STRUCTURE
//   npc_pkg: FSM enum {RUN, IND_WAIT}, status bit indices Z_BIT=0 and N_BIT=1, PC_STEP=4.
//   Sub-module npc_flag_reg: 2-bit status register with write enable and async reset.
//   The top level holds the FSM, PC register and select/link logic.
// TESTING
//   Reset, then 3 idle cycles -> pc 0,4,8,12; s1=s2=s3=0.
//   flag_we, alu_zero=1; next cycle balrv, read_data1=0x100 -> s1=1, pc=0x100, link_we=1, link_data=old pc+4.
//   Status N=0; baln, jump_target=0x200 -> s2=0, pc=pc+4, no link.
//   jmxor, read_data1=0x40; mem_ack after 3 cycles with rdata=0x300 -> stall=1 and mem_addr=0x40 for 4 cycles.
//     pc held, then pc=0x300, stall=0.
//   jmxor+jsp same cycle -> s3 path only, no link.
//   rst_n low during IND_WAIT -> mem_req=0, pc=RESET_PC.
//   pc=0xFFFF_FFFC idle -> pc=0 (wrap).
//   NPC_ALIGN_CHK_EN: jsp to 0x102 -> pc=pc+4, align_err=1 and stays 1.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg
//   Shared definitions for the next-PC select unit: FSM state encoding,
//   status flag bit positions and the sequential PC increment.
package npc_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    IND_WAIT = 1'b1
  } npc_state_e;

  localparam int Z_BIT   = 0;
  localparam int N_BIT   = 1;
  localparam int PC_STEP = 4;

endpackage : npc_pkg

// File: rtl/npc_flag_reg.sv
// npc_flag_reg
//   2-bit status register (Z in bit 0, N in bit 1) with write enable.
// Ports
//   clk    in   core clock, rising edge
//   rst_n  in   async active-low reset, clears both flags
//   we     in   load d at the clock edge
//   d      in   new {N, Z}
//   q      out  registered {N, Z}
module npc_flag_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] status_q;
  logic [1:0] status_d;

  always_comb begin
    status_d = status_q;
    if (we) status_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= 2'b00;
    else        status_q <= status_d;
  end

  assign q = status_q;

endmodule : npc_flag_reg

// File: rtl/npc_select_unit.sv
// npc_select_unit
//   Owns the PC and the Z/N status flags, generates the next-PC mux selects
//   s1/s2/s3, sequences the memory-indirect jump (jmxor) as a req/ack read
//   while stalling the core, and drives the link write for taken balrv/baln.
//
//   Optional feature macro: NPC_ALIGN_CHK_EN. When defined, a misaligned
//   branch target or indirect read result is not loaded; the PC steps by 4
//   instead and the sticky align_err flag sets. When undefined, targets load
//   unchanged and align_err is tied low.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   balrv, baln, jmxor, jsp    decoded control-transfer instructions
//   flag_we, alu_zero, alu_neg status flag update from the ALU
//   read_data1                 register target (s1) / indirect pointer (jmxor)
//   jump_target                decoded jump target (s2)
//   mem_rdata, mem_ack         indirect read response
//   pc                         current PC
//   s1, s2, s3                 next-PC mux selects
//   mem_req, mem_addr          indirect read request (held until mem_ack)
//   stall                      freeze fetch/decode during the indirect read
//   link_we, link_data         link register write (pc+4)
//   align_err                  sticky misaligned-target flag
//
// State      | Meaning
// -----------+-----------------------------------------------------------
// RUN        | normal sequencing; selects active, PC advances or branches
// IND_WAIT   | indirect read outstanding; mem_req/stall high, PC/flags hold
module npc_select_unit
  import npc_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              balrv,
  input  logic              baln,
  input  logic              jmxor,
  input  logic              jsp,
  input  logic              flag_we,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic [ADDR_W-1:0] read_data1,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              stall,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              align_err
);

  npc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        status;
  logic              run;
  logic              taken_balrv;
  logic [ADDR_W-1:0] pc_plus4;
  logic              load_tgt;
  logic              pc_adv;
  logic [ADDR_W-1:0] tgt;

  // Flags only update while running; an instruction waiting on the
  // indirect read must not clobber the status seen by later branches.
  npc_flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (flag_we & run),
    .d     ({alu_neg, alu_zero}),
    .q     (status)
  );

  assign run         = (state_q == RUN);
  assign taken_balrv = balrv & status[Z_BIT];
  assign pc_plus4    = pc_q + ADDR_W'(PC_STEP);

  assign s3 = run & jmxor;
  assign s2 = run & baln & status[N_BIT];
  assign s1 = run & (taken_balrv | jsp);

  // jmxor overrides any simultaneous branch, so it also suppresses the link.
  assign link_we   = run & ~jmxor & (s2 | taken_balrv);
  assign link_data = pc_plus4;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    load_tgt   = 1'b0;
    pc_adv     = 1'b0;
    tgt        = jump_target;
    case (state_q)
      RUN: begin
        if (s3) begin
          state_d    = IND_WAIT;
          mem_addr_d = read_data1;
        end else if (s2) begin
          load_tgt = 1'b1;
          tgt      = jump_target;
        end else if (s1) begin
          load_tgt = 1'b1;
          tgt      = read_data1;
        end else begin
          pc_adv = 1'b1;
        end
      end
      IND_WAIT: begin
        if (mem_ack) begin
          load_tgt = 1'b1;
          tgt      = mem_rdata;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_adv) begin
      pc_d = pc_plus4;
    end else if (load_tgt) begin
`ifdef NPC_ALIGN_CHK_EN
      if (tgt[1:0] != 2'b00) pc_d = pc_plus4;
      else                   pc_d = tgt;
`else
      pc_d = tgt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

`ifdef NPC_ALIGN_CHK_EN
  logic align_err_q, align_err_d;

  always_comb begin
    align_err_d = align_err_q | (load_tgt & (tgt[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_err_q <= 1'b0;
    else        align_err_q <= align_err_d;
  end

  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

  // mem_req/stall come straight from the state flop so that reset drops
  // them asynchronously mid-read.
  assign mem_req  = (state_q == IND_WAIT);
  assign stall    = (state_q == IND_WAIT);
  assign mem_addr = mem_addr_q;
  assign pc       = pc_q;

endmodule : npc_select_unit

// File: tb/tb_npc_select_unit.sv
// tb_npc_select_unit
//   Directed-vector bench for npc_select_unit with hand-computed expectations.
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_npc_select_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              balrv, baln, jmxor, jsp;
  logic              flag_we, alu_zero, alu_neg;
  logic [ADDR_W-1:0] read_data1, jump_target, mem_rdata;
  logic              mem_ack;
  logic [ADDR_W-1:0] pc, mem_addr, link_data;
  logic              s1, s2, s3, mem_req, stall, link_we, align_err;

  int n_pass  = 0;
  int n_total = 0;

  npc_select_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .balrv       (balrv),
    .baln        (baln),
    .jmxor       (jmxor),
    .jsp         (jsp),
    .flag_we     (flag_we),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .read_data1  (read_data1),
    .jump_target (jump_target),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .pc          (pc),
    .s1          (s1),
    .s2          (s2),
    .s3          (s3),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .stall       (stall),
    .link_we     (link_we),
    .link_data   (link_data),
    .align_err   (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b1; balrv = 0; baln = 0; jmxor = 0; jsp = 0;
    flag_we = 0; alu_zero = 0; alu_neg = 0;
    read_data1 = '0; jump_target = '0; mem_rdata = '0; mem_ack = 0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_pc", pc, 32'h0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_link_we", link_we, 0);
    chk("rst_align_err", align_err, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_sel", {s3, s2, s1}, 3'b000);

    tick(); chk("idle_pc1", pc, 32'h4);
    tick(); chk("idle_pc2", pc, 32'h8);
    tick(); chk("idle_pc3", pc, 32'hC);

    // set Z
    flag_we = 1; alu_zero = 1;
    tick(); chk("flagz_pc", pc, 32'h10);
    flag_we = 0; alu_zero = 0;

    balrv = 1; read_data1 = 32'h100;
    #1;
    chk("balrv_s1", s1, 1);
    chk("balrv_s2s3", {s3, s2}, 2'b00);
    chk("balrv_link_we", link_we, 1);
    chk("balrv_link_data", link_data, 32'h14);
    tick(); chk("balrv_pc", pc, 32'h100);
    balrv = 0;
    #1 chk("balrv_link_off", link_we, 0);

    // N=0: baln not taken
    baln = 1; jump_target = 32'h200;
    #1;
    chk("baln_nt_s2", s2, 0);
    chk("baln_nt_link", link_we, 0);
    tick(); chk("baln_nt_pc", pc, 32'h104);
    baln = 0;

    // indirect jump
    jmxor = 1; read_data1 = 32'h40;
    #1 chk("jmx_s3", s3, 1);
    tick();
    jmxor = 0; read_data1 = '0;
    jsp = 1; flag_we = 1; alu_neg = 1;
    #1;
    chk("jmx_c1_stall", stall, 1);
    chk("jmx_c1_req", mem_req, 1);
    chk("jmx_c1_addr", mem_addr, 32'h40);
    chk("jmx_c1_pc", pc, 32'h104);
    chk("jmx_c1_sel", {s3, s2, s1}, 3'b000);
    tick();
    jsp = 0; flag_we = 0; alu_neg = 0;
    chk("jmx_c2_stall", stall, 1);
    chk("jmx_c2_addr", mem_addr, 32'h40);
    chk("jmx_c2_pc", pc, 32'h104);
    tick();
    chk("jmx_c3_stall", stall, 1);
    chk("jmx_c3_addr", mem_addr, 32'h40);
    tick();
    mem_ack = 1; mem_rdata = 32'h300;
    chk("jmx_c4_stall", stall, 1);
    chk("jmx_c4_addr", mem_addr, 32'h40);
    chk("jmx_c4_pc", pc, 32'h104);
    tick();
    mem_ack = 0; mem_rdata = '0;
    chk("jmx_done_pc", pc, 32'h300);
    chk("jmx_done_stall", stall, 0);
    chk("jmx_done_req", mem_req, 0);

    // flag_we during the wait must have been ignored: N still 0
    baln = 1; jump_target = 32'h500;
    #1 chk("n_held_s2", s2, 0);
    baln = 0;

    // stray ack in RUN
    mem_ack = 1; mem_rdata = 32'h800;
    tick(); chk("ack_run_pc", pc, 32'h304);
    mem_ack = 0; mem_rdata = '0;

    // jmxor with jsp and taken balrv: s3 wins, no link
    jmxor = 1; jsp = 1; balrv = 1; read_data1 = 32'h60;
    #1;
    chk("s3win_s3", s3, 1);
    chk("s3win_link", link_we, 0);
    tick();
    jmxor = 0; jsp = 0; balrv = 0; read_data1 = '0;
    chk("s3win_stall", stall, 1);
    chk("s3win_addr", mem_addr, 32'h60);
    chk("s3win_pc", pc, 32'h304);

    // async reset mid-read
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req", mem_req, 0);
    chk("abort_stall", stall, 0);
    chk("abort_pc", pc, 32'h0);
    #1 rst_n = 1'b1;

    // jsp alone: taken but never links; then wrap
    jsp = 1; read_data1 = 32'hFFFF_FFFC;
    #1;
    chk("jsp_s1", s1, 1);
    chk("jsp_link", link_we, 0);
    tick(); chk("jsp_pc", pc, 32'hFFFF_FFFC);
    jsp = 0; read_data1 = '0;
    tick(); chk("wrap_pc", pc, 32'h0);

    // set N (Z cleared by reset, stays 0)
    flag_we = 1; alu_neg = 1;
    tick(); chk("flagn_pc", pc, 32'h4);
    flag_we = 0; alu_neg = 0;

    baln = 1; jump_target = 32'h200; balrv = 1; read_data1 = 32'h700;
    #1;
    chk("baln_s2", s2, 1);
    chk("baln_s1", s1, 0);
    chk("baln_link_we", link_we, 1);
    chk("baln_link_data", link_data, 32'h8);
    tick(); chk("baln_pc", pc, 32'h200);
    baln = 0; balrv = 0; read_data1 = '0;

    // misaligned register target
    jsp = 1; read_data1 = 32'h102;
    tick();
    jsp = 0; read_data1 = '0;
`ifdef NPC_ALIGN_CHK_EN
    chk("mis_pc", pc, 32'h204);
    chk("mis_err", align_err, 1);
    tick();
    chk("mis_pc2", pc, 32'h208);
    chk("mis_err_sticky", align_err, 1);
`else
    chk("mis_pc", pc, 32'h102);
    chk("mis_err", align_err, 0);
    tick();
    chk("mis_pc2", pc, 32'h106);
    chk("mis_err_tied", align_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_npc_select_unit
